// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port (read-only) and the data port (read/write).
// Grants are combinational. Read data returns one cycle after the grant.
// The data port has priority. A starvation counter forces a fetch grant
// after MAX_WAIT consecutive denied fetch cycles.
module imem_dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    if_flush_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,

    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,

    output logic                    mem_ren_o,
    output logic                    mem_wen_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int         BE_W       = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    // Owner of the read response that the memory returns this cycle
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_owner_t;

    resp_owner_t resp_owner;
    resp_owner_t resp_owner_nxt;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_nxt;

    logic        if_starved;
    logic        if_win;
    logic        d_win;
    logic        resp_if;
    logic        resp_d;

    // Arbitration: the data port wins a tie unless the fetch port has waited too long.
    // Every grant is held low while reset is asserted.
    always_comb begin
        if_starved = (starve_cnt == WAIT_LIMIT);
        if_win     = rst_n && if_req_i && (!d_req_i || if_starved);
        d_win      = rst_n && d_req_i && !if_win;
    end

    // Starvation count: counts consecutive denied fetch cycles and saturates at the limit
    always_comb begin
        starve_cnt_nxt = '0;
        if (if_req_i && !if_win) begin
            if (starve_cnt >= WAIT_LIMIT) begin
                starve_cnt_nxt = WAIT_LIMIT;
            end else begin
                starve_cnt_nxt = starve_cnt + 4'd1;
            end
        end
    end

    // Response owner for next cycle: only read grants produce a response
    always_comb begin
        resp_owner_nxt = RESP_NONE;
        if (if_win) begin
            resp_owner_nxt = RESP_IF;
        end else if (d_win && !d_we_i) begin
            resp_owner_nxt = RESP_D;
        end
    end

    // State registers. An asynchronous reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner <= RESP_NONE;
            starve_cnt <= '0;
        end else begin
            resp_owner <= resp_owner_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Decode the response owner. The unused encoding is treated as no owner.
    always_comb begin
        resp_if = 1'b0;
        resp_d  = 1'b0;
        case (resp_owner)
            RESP_IF: resp_if = 1'b1;
            RESP_D:  resp_d  = 1'b1;
            default: begin
                resp_if = 1'b0;
                resp_d  = 1'b0;
            end
        endcase
    end

    // Response outputs. A flush in the response cycle hides the fetch data.
    always_comb begin
        if_gnt_o    = if_win;
        d_gnt_o     = d_win;
        if_rvalid_o = rst_n && resp_if && !if_flush_i;
        d_rvalid_o  = rst_n && resp_d;
        if_rdata_o  = mem_rdata_i;
        d_rdata_o   = mem_rdata_i;
    end

    // Memory command for the winner of this cycle
    always_comb begin
        mem_ren_o   = if_win || (d_win && !d_we_i);
        mem_wen_o   = d_win && d_we_i;
        mem_addr_o  = if_win ? if_addr_i : d_addr_i;
        mem_be_o    = (d_win && d_we_i) ? d_be_i : {BE_W{1'b0}};
        mem_wdata_o = d_wdata_i;
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter. A behavioural memory serves the DUT.
// A reference model checks the outputs on every cycle. The stimulus is a
// directed scenario sequence followed by a randomized phase.
module tb_imem_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MW = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_flush_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [BW-1:0] d_be_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o;
    logic          d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_ren_o;
    logic          mem_wen_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    // Memory contents seen by the DUT, and the reference copy kept by the model
    logic [DW-1:0] env_mem  [256];
    logic [DW-1:0] gold_mem [256];

    // Model state
    int            m_wait;
    int            m_pend;
    logic [DW-1:0] m_data;
    logic          e_if_gnt;
    logic          e_d_gnt;
    logic          e_ren;
    logic          e_wen;

    imem_dmem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_flush_i (if_flush_i),
        .if_gnt_o   (if_gnt_o),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o (if_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_be_i     (d_be_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_rdata_o  (d_rdata_o),
        .mem_ren_o  (mem_ren_o),
        .mem_wen_o  (mem_wen_o),
        .mem_be_o   (mem_be_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req_i   = 1'b0;
        if_flush_i = 1'b0;
        d_req_i    = 1'b0;
        d_we_i     = 1'b0;
    endtask

    // Single-port synchronous memory. The command is captured mid-cycle and
    // executed at the clock edge.
    initial begin
        logic          ren, wen;
        logic [7:0]    idx;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
        forever begin
            @(negedge clk);
            ren = mem_ren_o;
            wen = mem_wen_o;
            idx = mem_addr_o[9:2];
            be  = mem_be_o;
            wd  = mem_wdata_o;
            @(posedge clk);
            if (wen) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[b]) env_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
            if (ren) mem_rdata_i = env_mem[idx];
        end
    end

    // Reference model and per-cycle compare
    initial begin
        m_wait = 0;
        m_pend = 0;
        m_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk1("rst_if_gnt", if_gnt_o, 1'b0);
                chk1("rst_d_gnt", d_gnt_o, 1'b0);
                chk1("rst_if_rvalid", if_rvalid_o, 1'b0);
                chk1("rst_d_rvalid", d_rvalid_o, 1'b0);
                chk1("rst_mem_ren", mem_ren_o, 1'b0);
                chk1("rst_mem_wen", mem_wen_o, 1'b0);
                m_wait = 0;
                m_pend = 0;
            end else begin
                // The fetch port wins when alone, or after MW consecutive losses
                e_if_gnt = if_req_i && (!d_req_i || (m_wait == MW));
                e_d_gnt  = d_req_i && !e_if_gnt;
                e_ren    = e_if_gnt || (e_d_gnt && !d_we_i);
                e_wen    = e_d_gnt && d_we_i;
                chk1("if_gnt", if_gnt_o, e_if_gnt);
                chk1("d_gnt", d_gnt_o, e_d_gnt);
                chk1("mem_ren", mem_ren_o, e_ren);
                chk1("mem_wen", mem_wen_o, e_wen);
                if (e_if_gnt) chk("mem_addr_if", mem_addr_o, if_addr_i);
                if (e_d_gnt) chk("mem_addr_d", mem_addr_o, d_addr_i);
                if (e_wen) begin
                    chk("mem_be", 32'(mem_be_o), 32'(d_be_i));
                    chk("mem_wdata", mem_wdata_o, d_wdata_i);
                end
                chk1("if_rvalid", if_rvalid_o, (m_pend == 1) && !if_flush_i);
                chk1("d_rvalid", d_rvalid_o, m_pend == 2);
                if ((m_pend == 1) && !if_flush_i) chk("if_rdata", if_rdata_o, m_data);
                if (m_pend == 2) chk("d_rdata", d_rdata_o, m_data);

                m_pend = 0;
                if (e_if_gnt) begin
                    m_pend = 1;
                    m_data = gold_mem[if_addr_i[9:2]];
                end else if (e_d_gnt && !d_we_i) begin
                    m_pend = 2;
                    m_data = gold_mem[d_addr_i[9:2]];
                end
                if (e_wen) begin
                    for (int b = 0; b < BW; b++) begin
                        if (d_be_i[b]) gold_mem[d_addr_i[9:2]][8*b +: 8] = d_wdata_i[8*b +: 8];
                    end
                end
                if (if_req_i && !e_if_gnt) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
                else m_wait = 0;
            end
        end
    end

    // Stimulus
    initial begin
        logic gi, gd;
        for (int i = 0; i < 256; i++) begin
            env_mem[i]  = 32'h1000_0000 + 32'(i * 4);
            gold_mem[i] = 32'h1000_0000 + 32'(i * 4);
        end
        env_mem[8'h40]  = '0;
        gold_mem[8'h40] = '0;
        mem_rdata_i = '0;
        rst_n       = 1'b0;
        if_addr_i   = '0;
        d_addr_i    = '0;
        d_be_i      = '0;
        d_wdata_i   = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Fetch-only stream at 0x0, 0x4, 0x8
        if_req_i = 1'b1; if_addr_i = 32'h0;
        @(negedge clk); chk1("t1_gnt0", if_gnt_o, 1'b1);
        tick();
        if_addr_i = 32'h4;
        @(negedge clk); chk1("t1_gnt1", if_gnt_o, 1'b1);
        chk1("t1_rv0", if_rvalid_o, 1'b1); chk("t1_rd0", if_rdata_o, 32'h1000_0000);
        tick();
        if_addr_i = 32'h8;
        @(negedge clk); chk1("t1_gnt2", if_gnt_o, 1'b1);
        chk1("t1_rv1", if_rvalid_o, 1'b1); chk("t1_rd1", if_rdata_o, 32'h1000_0004);
        tick();
        idle();
        @(negedge clk); chk1("t1_rv2", if_rvalid_o, 1'b1); chk("t1_rd2", if_rdata_o, 32'h1000_0008);
        tick();

        // Both ports requesting for six cycles: fetch is forced through on cycle 4
        if_req_i = 1'b1; if_addr_i = 32'hC;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk1("t2_d_gnt", d_gnt_o, c != 4);
            chk1("t2_if_gnt", if_gnt_o, c == 4);
            tick();
        end
        idle();
        tick();

        // Partial write then read back over a zero word
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
        d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk); chk1("t3_wgnt", d_gnt_o, 1'b1); chk1("t3_wen", mem_wen_o, 1'b1);
        chk1("t3_wren", mem_ren_o, 1'b0);
        tick();
        d_we_i = 1'b0;
        @(negedge clk); chk1("t3_no_rv", d_rvalid_o, 1'b0); chk1("t3_ren", mem_ren_o, 1'b1);
        tick();
        idle();
        @(negedge clk); chk1("t3_rv", d_rvalid_o, 1'b1); chk("t3_rd", d_rdata_o, 32'h0000_BEEF);
        tick();

        // Flush in the response cycle alongside a new fetch grant
        if_req_i = 1'b1; if_addr_i = 32'h20;
        @(negedge clk); chk1("t4_gnt0", if_gnt_o, 1'b1);
        tick();
        if_addr_i = 32'h40; if_flush_i = 1'b1;
        @(negedge clk); chk1("t4_gnt1", if_gnt_o, 1'b1); chk1("t4_flushed", if_rvalid_o, 1'b0);
        tick();
        idle();
        @(negedge clk); chk1("t4_rv", if_rvalid_o, 1'b1); chk("t4_rd", if_rdata_o, 32'h1000_0040);
        tick();

        // Asynchronous reset while a data read response is pending
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h10;
        @(negedge clk); chk1("t5_gnt", d_gnt_o, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t5_rv", d_rvalid_o, 1'b0); chk1("t5_ren", mem_ren_o, 1'b0);
        chk1("t5_wen", mem_wen_o, 1'b0); chk1("t5_gnt_rst", d_gnt_o, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); chk1("t5_no_stale", d_rvalid_o, 1'b0);
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h4; d_req_i = 1'b1; d_addr_i = 32'h8;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("t5_starve_if", if_gnt_o, c == 4);
            tick();
        end
        idle();
        tick();

        // Randomized traffic with flushes, withdrawals and partial writes
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            gi = if_gnt_o;
            gd = d_gnt_o;
            @(posedge clk);
            #1;
            if_flush_i = ($urandom_range(0, 7) == 0);
            if (gi || !if_req_i) begin
                if_req_i  = ($urandom_range(0, 3) != 0);
                if_addr_i = 32'($urandom_range(0, 255)) << 2;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req_i = 1'b0;
            end
            if (gd || !d_req_i) begin
                d_req_i   = ($urandom_range(0, 3) != 0);
                d_we_i    = ($urandom_range(0, 2) == 0);
                d_be_i    = 4'($urandom_range(0, 15));
                d_addr_i  = 32'($urandom_range(0, 255)) << 2;
                d_wdata_i = $urandom();
            end else if ($urandom_range(0, 15) == 0) begin
                d_req_i = 1'b0;
            end
        end
        idle();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
